// File: rtl/serial_initiator_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : serial_initiator_tx
//  Function : Initiator-side serializer. Shifts one write request out as an
//             address phase (LSB first, mode=0), waits for a target ack with
//             a timeout, then shifts the data phase (LSB first, mode=1).
//  Revision : 1.0 - initial release
// ============================================================================
module serial_initiator_tx #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic                  bus_grant,
   input  logic                  target_ack,
   output logic                  bus_data_out,
   output logic                  bus_data_out_valid,
   output logic                  bus_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // One counter serves both phases, so it is sized for the longer one.
   localparam int BIT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
   localparam int TMO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ADDR     = 2'd1,
      WAIT_ACK = 2'd2,
      DATA     = 2'd3
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_sh;
   logic [DATA_WIDTH-1:0]   data_sh;
   logic [CNT_W-1:0]        bit_cnt;
   logic [TMO_W-1:0]        tmo_cnt;
   logic                    mode_q;
   logic                    done_q;
   logic                    err_q;

   // Transaction sequencer: shifting, phase changes, timeout and result pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_sh <= '0;
         data_sh <= '0;
         bit_cnt <= '0;
         tmo_cnt <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               // req_ready is implied by being in IDLE.
               if (req_valid) begin
                  addr_sh <= req_addr;
                  data_sh <= req_data;
                  bit_cnt <= '0;
                  state   <= ADDR;
               end
            end
            ADDR: begin
               if (bus_grant) begin
                  addr_sh <= addr_sh >> 1;
                  if (bit_cnt == ADDR_LAST) begin
                     bit_cnt <= '0;
                     tmo_cnt <= '0;
                     mode_q  <= 1'b1;
                     state   <= WAIT_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            WAIT_ACK: begin
               // An ack arriving on the expiry cycle still wins.
               if (target_ack) begin
                  bit_cnt <= '0;
                  state   <= DATA;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt <= '0;
                  mode_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            DATA: begin
               if (bus_grant) begin
                  data_sh <= data_sh >> 1;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     mode_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Serial bit and its strobe; the strobe follows grant so a stalled bit is held.
   always_comb begin
      bus_data_out       = 1'b0;
      bus_data_out_valid = 1'b0;
      case (state)
         ADDR: begin
            bus_data_out       = addr_sh[0];
            bus_data_out_valid = bus_grant;
         end
         DATA: begin
            bus_data_out       = data_sh[0];
            bus_data_out_valid = bus_grant;
         end
         default: begin
            bus_data_out       = 1'b0;
            bus_data_out_valid = 1'b0;
         end
      endcase
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign bus_mode  = mode_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/serial_initiator_tx.md
Name: serial_initiator_tx

Overview:
- Initiator-side serializer for the serial bus. Drives the single-bit data line, its valid strobe and the address/data mode flag.
- Accepts one parallel write request (address + data) and shifts it out in two phases:
  - 16 address bits, LSB first, with bus_mode=0.
  - then 8 data bits, LSB first, with bus_mode=1.
- Between the phases it waits for the decode path to acknowledge a selected target, with a timeout.
- Sits between an initiator's request logic and the bus mux/arbiter.

Parameters:
ADDR_WIDTH, 16, address bits serialized per transaction
DATA_WIDTH, 8, data bits serialized per transaction
ACK_TIMEOUT, 4, cycles spent in WAIT_ACK before abort (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_addr  input  ADDR_WIDTH  target address, captured on accept
req_data  input  DATA_WIDTH  write data, captured on accept
bus_grant  input  1  arbiter grant; bits advance only while high
target_ack  input  1  OR of decoded target-valid lines; sampled only in WAIT_ACK
bus_data_out  output  1  serial bit
bus_data_out_valid  output  1  bus_data_out carries a bit this cycle
bus_mode  output  1  0 = address phase, 1 = data phase
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, transaction completed
err  output  1  one-cycle pulse, ack timeout abort

Behaviour:
- Reset (async, rst_n=0): state=IDLE; shift registers, bit counter and timeout counter cleared.
  - Outputs: req_ready=1; bus_data_out, bus_data_out_valid, bus_mode, busy, done, err = 0.
  - Reset mid-transaction aborts with no done/err pulse.
- States: IDLE, ADDR, WAIT_ACK, DATA.
- IDLE:
  - req_ready=1.
  - Accept when req_valid && req_ready: load addr_sh<=req_addr, data_sh<=req_data, bit_cnt<=0, go to ADDR.
  - req_valid while busy is ignored; no queueing.
- ADDR:
  - bus_mode=0.
  - bus_data_out=addr_sh[0].
  - bus_data_out_valid=bus_grant (combinational).
  - On a cycle with grant high: shift addr_sh right, bit_cnt++.
  - When bit_cnt==ADDR_WIDTH-1 and grant high: go to WAIT_ACK, clear bit_cnt and timeout counter.
  - Grant low: no bit consumed, current bit held, counters frozen.
- WAIT_ACK:
  - bus_mode=1, bus_data_out_valid=0.
  - target_ack high: go to DATA.
  - Otherwise tmo_cnt++. When tmo_cnt==ACK_TIMEOUT-1 with no ack: go to IDLE and pulse err.
  - Ack in the same cycle as expiry: ack wins, no err.
  - Exactly ACK_TIMEOUT cycles are spent before abort.
- DATA:
  - bus_mode=1.
  - bus_data_out=data_sh[0].
  - bus_data_out_valid=bus_grant.
  - Same shift/freeze rules as ADDR.
  - On the DATA_WIDTH-th granted bit: go to IDLE and pulse done.
  - target_ack is ignored in this state.
- done and err:
  - Registered pulses, high for exactly the first IDLE cycle after completion or abort.
  - done and err are never high together.
- bus_mode=0 in IDLE.
- Back-to-back:
  - req_ready is high in the done/err cycle, so a request can be accepted there.
  - Its first address bit appears the next cycle.
- Latency, request accepted at edge T, grant continuous, ack at the first WAIT_ACK cycle:

| Event | Cycles |
|---|---|
| Address bits | T+1..T+16 |
| WAIT_ACK | T+17 |
| Data bits | T+18..T+25 |
| done | T+26 |

- busy is high from T+1 through the last DATA/WAIT_ACK cycle.

Test Plan:
1. Normal write.
   - Stimulus: req_addr=0x4123, req_data=0xA5, grant=1, ack at T+17.
   - Address phase: bus_data_out = 1,1,0,0,0,1,0,0,1,0,0,0,0,0,1,0 with mode=0 over T+1..T+16.
   - Data phase: 1,0,1,0,0,1,0,1 with mode=1 over T+18..T+25.
   - done=1 at T+26 only; err never set.
2. Grant stall.
   - Stimulus: grant dropped for 3 cycles after address bit 5.
   - valid=0 for those 3 cycles; bit 6 is held and emitted when grant returns.
   - Address phase spans 19 cycles; the serial sequence is identical to scenario 1.
3. Timeout.
   - Stimulus: req_addr=0xF000 (unmapped), ack never asserted.
   - WAIT_ACK spans T+17..T+20; err=1 at T+21.
   - No data-phase valid cycles; done stays 0; req_ready=1 at T+21.
4. Late ack.
   - Stimulus: ack asserted only at T+20, the final timeout cycle.
   - DATA entered at T+21, no err, done at T+29.
5. Busy and back-to-back.
   - Stimulus: req_valid held high with changing req_addr during a transaction.
   - Requests are ignored while busy (req_ready=0).
   - A second request presented in the done cycle is accepted there; its bit 0 appears the following cycle with mode=0.
6. Reset mid-transaction.
   - Stimulus: rst_n pulled low during the DATA phase.
   - Outputs immediately show valid=0, mode=0, busy=0, done=0, err=0, req_ready=1.
   - After release, a new request completes normally.
